// File: rtl/display_tx_scheduler_pkg.sv
// Shared types and constants for the display TX scheduler.
// Build option HOST_CRLF_EN selects the host character transform in the top level.
package display_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef enum logic {
    SRC_CPU  = 1'b0,
    SRC_HOST = 1'b1
  } source_t;

  localparam logic [7:0] CHR_CR = 8'h8D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  localparam int CLEAR_TICKS_DEFAULT = 119210;
  localparam int CLEAR_CNT_W         = 17;

  // The display ignores LF, so it becomes CR; everything else is shown with bit7 set.
  function automatic logic [7:0] host_xform(input logic [7:0] c);
    if (c == CHR_LF) return CHR_CR;
    return c | 8'h80;
  endfunction

endpackage

// File: rtl/display_tx_scheduler_if.sv
// Display TX port bundle between the scheduler (master) and the display (slave).
interface display_tx_scheduler_if;
  // Handshake: once disp_w_en rises, disp_w_en and disp_din stay constant until the
  // cycle in which disp_ready (qualified by both clock enables) is sampled high at
  // posedge; that edge is the transfer, and disp_w_en drops in the next cycle.
  logic       disp_address;
  logic       disp_w_en;
  logic [7:0] disp_din;
  logic       disp_ready;
  logic       disp_clr_screen;

  modport master (
    output disp_address,
    output disp_w_en,
    output disp_din,
    output disp_clr_screen,
    input  disp_ready
  );

  modport slave (
    input  disp_address,
    input  disp_w_en,
    input  disp_din,
    input  disp_clr_screen,
    output disp_ready
  );
endinterface

// File: rtl/display_tx_scheduler_host_char_fifo.sv
// Synchronous character FIFO: valid/ready push side, pop strobe on the read side.
module host_char_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ready = ~full;
  assign push       = push_valid & ~full;
  assign pop_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)          wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/display_tx_scheduler.sv
// Arbitrates CPU and host characters onto the display TX port and owns screen clear.
// Build option: define HOST_CRLF_EN to map host LF to CR and set bit7 on other host chars.
module display_tx_scheduler
  import display_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CLEAR_TICKS = CLEAR_TICKS_DEFAULT
) (
  input  logic                          sys_clock,
  input  logic                          reset,
  input  logic                          pixel_clken,
  input  logic                          cpu_clken,
  input  logic                          cpu_wr,
  input  logic [7:0]                    cpu_din,
  output logic                          cpu_busy,
  input  logic                          host_valid,
  input  logic [7:0]                    host_data,
  output logic                          host_ready,
  input  logic                          clr_req,
  output logic                          clr_busy,
  output logic                          cpu_drop,
  display_tx_scheduler_if.master        disp,
  output state_t                        fsm_state
);
  localparam logic [CLEAR_CNT_W-1:0] LAST_TICK = CLEAR_CNT_W'(CLEAR_TICKS - 1);

  state_t                 state_q, state_d;
  source_t                last_grant_q, last_grant_d;
  logic                   w_en_q, w_en_d;
  logic [7:0]             din_q, din_d;
  logic [CLEAR_CNT_W-1:0] cnt_q, cnt_d;
  logic                   clr_pending_q, clr_pending_d;
  logic [7:0]             cpu_char_q;
  logic                   cpu_busy_q;
  logic                   cpu_drop_q;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [7:0]             fifo_data;
  logic [7:0]             host_char;
  logic                   accept;
  logic                   cpu_done;

  host_char_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .push_valid (host_valid),
    .push_data  (host_data),
    .push_ready (host_ready),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .empty      (fifo_empty)
  );

`ifdef HOST_CRLF_EN
  assign host_char = host_xform(fifo_data);
`else
  assign host_char = fifo_data;
`endif

  assign accept = w_en_q & disp.disp_ready & pixel_clken & cpu_clken;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    w_en_d        = w_en_q;
    din_d         = din_q;
    cnt_d         = cnt_q;
    clr_pending_d = clr_pending_q | clr_req;
    fifo_pop      = 1'b0;
    cpu_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_pending_q) begin
          state_d = CLEAR;
        end else if (cpu_busy_q || !fifo_empty) begin
          // CPU wins when it is alone or when the host was served last.
          if (cpu_busy_q && (fifo_empty || last_grant_q == SRC_HOST)) begin
            din_d        = cpu_char_q;
            last_grant_d = SRC_CPU;
          end else begin
            din_d        = host_char;
            fifo_pop     = 1'b1;
            last_grant_d = SRC_HOST;
          end
          w_en_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          w_en_d   = 1'b0;
          cpu_done = (last_grant_q == SRC_CPU);
          state_d  = IDLE;
        end
      end
      CLEAR: begin
        if (pixel_clken) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d         = '0;
            clr_pending_d = 1'b0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + CLEAR_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= SRC_HOST;
      w_en_q        <= 1'b0;
      din_q         <= '0;
      cnt_q         <= '0;
      clr_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      w_en_q        <= w_en_d;
      din_q         <= din_d;
      cnt_q         <= cnt_d;
      clr_pending_q <= clr_pending_d;
    end
  end

  // The slot stays occupied until its character is accepted, so a write landing in
  // the accept cycle itself is still dropped.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      cpu_busy_q <= 1'b0;
      cpu_drop_q <= 1'b0;
      cpu_char_q <= '0;
    end else begin
      cpu_drop_q <= cpu_wr & cpu_busy_q;
      if (cpu_wr && !cpu_busy_q) begin
        cpu_char_q <= cpu_din;
        cpu_busy_q <= 1'b1;
      end else if (cpu_done) begin
        cpu_busy_q <= 1'b0;
      end
    end
  end

  assign cpu_busy             = cpu_busy_q;
  assign cpu_drop             = cpu_drop_q;
  assign clr_busy             = (state_q == CLEAR);
  assign disp.disp_clr_screen = (state_q == CLEAR);
  assign disp.disp_w_en       = w_en_q;
  assign disp.disp_din        = din_q;
  assign disp.disp_address    = 1'b0;
  assign fsm_state            = state_q;

endmodule

// File: tb/tb_display_tx_scheduler.sv
// Self-checking bench for display_tx_scheduler: directed scenarios plus randomized host traffic.
`timescale 1ns/1ps
module tb_display_tx_scheduler;
  import display_tx_pkg::*;

  localparam int TB_FIFO_DEPTH  = 16;
  // A shortened frame keeps the clear scenario brief.
  localparam int TB_CLEAR_TICKS = 50;

  logic       sys_clock;
  logic       reset;
  logic       cpu_clken;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic       host_valid;
  logic [7:0] host_data;
  logic       clr_req;
  logic       half_rate;
  logic       pix_phase;
  logic       pix_en;
  logic       pixel_clken;
  logic       cpu_busy;
  logic       host_ready;
  logic       clr_busy;
  logic       cpu_drop;
  state_t     fsm_state;

  display_tx_scheduler_if dif();

  assign pixel_clken = half_rate ? pix_phase : pix_en;

  display_tx_scheduler #(
    .FIFO_DEPTH  (TB_FIFO_DEPTH),
    .CLEAR_TICKS (TB_CLEAR_TICKS)
  ) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .pixel_clken (pixel_clken),
    .cpu_clken   (cpu_clken),
    .cpu_wr      (cpu_wr),
    .cpu_din     (cpu_din),
    .cpu_busy    (cpu_busy),
    .host_valid  (host_valid),
    .host_data   (host_data),
    .host_ready  (host_ready),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .cpu_drop    (cpu_drop),
    .disp        (dif.master),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  initial pix_phase = 1'b0;
  always @(posedge sys_clock) begin
    #3;
    pix_phase = ~pix_phase;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int n_checks;
  int n_fail;
  int clr_ticks;
  int wen_in_clear;
  int gap_err;
  logic prev_acc;

  always @(negedge sys_clock) begin
    if (reset) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc && dif.disp_w_en) gap_err++;
      if (dif.disp_clr_screen) begin
        if (pixel_clken) clr_ticks++;
        if (dif.disp_w_en) wen_in_clear++;
      end
      prev_acc = dif.disp_w_en & dif.disp_ready & pixel_clken & cpu_clken;
      if (prev_acc) obs_q.push_back(dif.disp_din);
    end
  end

  function automatic logic [7:0] exp_host(input logic [7:0] c);
`ifdef HOST_CRLF_EN
    if (c == 8'h0A) return 8'h8D;
    return c | 8'h80;
`else
    return c;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    cpu_wr         = 1'b0;
    cpu_din        = 8'h00;
    host_valid     = 1'b0;
    host_data      = 8'h00;
    clr_req        = 1'b0;
    cpu_clken      = 1'b1;
    pix_en         = 1'b1;
    half_rate      = 1'b0;
    dif.disp_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic cpu_write(input logic [7:0] d);
    cpu_wr  = 1'b1;
    cpu_din = d;
    step();
    cpu_wr  = 1'b0;
  endtask

  task automatic ready_pulse();
    dif.disp_ready = 1'b1;
    step();
    dif.disp_ready = 1'b0;
    step();
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_busy: got %b want 0", cpu_busy); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
    n_checks++; if (dif.disp_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en: got %b want 0", dif.disp_w_en); end
    n_checks++; if (dif.disp_din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h want 00", dif.disp_din); end
    n_checks++; if (dif.disp_clr_screen !== 1'b0) begin n_fail++; $display("FAIL reset_clr_screen: got %b want 0", dif.disp_clr_screen); end
    n_checks++; if (cpu_drop !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_drop: got %b want 0", cpu_drop); end
    n_checks++; if (dif.disp_address !== 1'b0) begin n_fail++; $display("FAIL reset_address: got %b want 0", dif.disp_address); end
    n_checks++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
    // Reset while a character is held must abandon it.
    cpu_write(8'h99);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (dif.disp_w_en !== 1'b0) begin n_fail++; $display("FAIL midreset_w_en: got %b want 0", dif.disp_w_en); end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_cpu_busy: got %b want 0", cpu_busy); end
  endtask

  task automatic test_single_cpu();
    apply_reset();
    dif.disp_ready = 1'b1;
    cpu_write(8'hC1);
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_set: got %b want 1", cpu_busy); end
    n_checks++; if (dif.disp_w_en !== 1'b0) begin n_fail++; $display("FAIL single_w_en_c1: got %b want 0", dif.disp_w_en); end
    step();
    n_checks++; if (dif.disp_w_en !== 1'b1) begin n_fail++; $display("FAIL single_w_en_c2: got %b want 1", dif.disp_w_en); end
    n_checks++; if (dif.disp_din !== 8'hC1) begin n_fail++; $display("FAIL single_din: got %h want c1", dif.disp_din); end
    step();
    n_checks++; if (dif.disp_w_en !== 1'b0) begin n_fail++; $display("FAIL single_w_en_drop: got %b want 0", dif.disp_w_en); end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clr: got %b want 0", cpu_busy); end
    n_checks++; if (dif.disp_din !== 8'hC1) begin n_fail++; $display("FAIL single_din_retain: got %h want c1", dif.disp_din); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_writes: got %0d want 1", obs_q.size()); end
  endtask

  task automatic test_ready_stall();
    int bad;
    apply_reset();
    cpu_write(8'hB0);
    step();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (dif.disp_w_en !== 1'b1 || dif.disp_din !== 8'hB0) begin
        n_fail++;
        bad++;
        if (bad < 4) $display("FAIL stall_hold cycle %0d: w_en=%b din=%h want 1/b0", i, dif.disp_w_en, dif.disp_din);
      end
      step();
    end
    dif.disp_ready = 1'b1;
    step();
    n_checks++; if (dif.disp_w_en !== 1'b0) begin n_fail++; $display("FAIL stall_accept: w_en=%b want 0 after first ready", dif.disp_w_en); end
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'hB0) begin
      n_fail++;
      $display("FAIL stall_write: got %0d writes want 1 of b0", obs_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e, o;
    apply_reset();
    cpu_wr     = 1'b1;
    cpu_din    = 8'hC1;
    host_valid = 1'b1;
    host_data  = 8'h31;
    step();
    cpu_wr    = 1'b0;
    host_data = 8'h32;
    step();
    host_valid = 1'b0;
    step();
    step();
    ready_pulse();
    cpu_write(8'hC2);
    step();
    ready_pulse();
    ready_pulse();
    ready_pulse();
    exp_q = '{8'hC1, exp_host(8'h31), 8'hC2, exp_host(8'h32)};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rr_order: got %h want %h", o, e); end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] e, o;
    logic [7:0] d;
    apply_reset();
    cpu_write(8'h5A);
    step();
    exp_q.push_back(8'h5A);
    for (int i = 0; i < TB_FIFO_DEPTH; i++) begin
      d          = 8'($urandom_range(0, 255));
      host_valid = 1'b1;
      host_data  = d;
      n_checks++;
      if (host_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_early push %0d: got %b want 1", i, host_ready); end
      exp_q.push_back(exp_host(d));
      step();
    end
    host_valid = 1'b0;
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", host_ready); end
    host_valid = 1'b1;
    host_data  = 8'hEE;
    step();
    host_valid = 1'b0;
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_17: got %b want 0", host_ready); end
    cpu_write(8'h77);
    n_checks++; if (cpu_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", cpu_drop); end
    step();
    n_checks++; if (cpu_drop !== 1'b0) begin n_fail++; $display("FAIL drop_width: got %b want 0", cpu_drop); end
    dif.disp_ready = 1'b1;
    for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) step();
    step();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL full_order: got %h want %h", o, e); end
    end
  endtask

  task automatic test_clear();
    logic [7:0] e, o;
    apply_reset();
    half_rate = 1'b1;
    cpu_write(8'hA5);
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (5) step();
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_wait_accept: clr_busy=%b want 0", clr_busy); end
    n_checks++; if (dif.disp_w_en !== 1'b1) begin n_fail++; $display("FAIL clr_hold_w_en: got %b want 1", dif.disp_w_en); end
    dif.disp_ready = 1'b1;
    clr_ticks      = 0;
    wen_in_clear   = 0;
    for (int i = 0; i < 20 && !dif.disp_clr_screen; i++) step();
    n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_start: clr_busy=%b want 1", clr_busy); end
    for (int i = 0; i < 4 * TB_CLEAR_TICKS + 20 && dif.disp_clr_screen; i++) begin
      cpu_wr  = (i == 10);
      cpu_din = 8'hD7;
      clr_req = (i == 20);
      step();
    end
    cpu_wr  = 1'b0;
    clr_req = 1'b0;
    n_checks++; if (dif.disp_clr_screen !== 1'b0) begin n_fail++; $display("FAIL clr_end: clr_screen=%b want 0", dif.disp_clr_screen); end
    n_checks++; if (clr_ticks != TB_CLEAR_TICKS) begin n_fail++; $display("FAIL clr_ticks: got %0d want %0d", clr_ticks, TB_CLEAR_TICKS); end
    n_checks++; if (wen_in_clear != 0) begin n_fail++; $display("FAIL clr_wen: got %0d cycles want 0", wen_in_clear); end
    exp_q = '{8'hA5, 8'hD7};
    for (int i = 0; i < 50 && obs_q.size() < exp_q.size(); i++) step();
    repeat (10) step();
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_absorb: clr_busy=%b want 0", clr_busy); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clr_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL clr_order: got %h want %h", o, e); end
    end
    half_rate = 1'b0;
  endtask

  task automatic test_host_xform();
    logic [7:0] e, o;
    logic [7:0] d;
    apply_reset();
    dif.disp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      d = 8'h0A;
      else if (i == 1) d = 8'h41;
      else             d = 8'($urandom_range(0, 255));
      host_valid = 1'b1;
      host_data  = d;
      if (host_ready) exp_q.push_back(exp_host(d));
      step();
    end
    host_valid = 1'b0;
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) step();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL xform_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL xform_char: got %h want %h", o, e); end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] e, o;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      host_valid     = ($urandom_range(0, 1) == 1);
      host_data      = 8'($urandom_range(0, 255));
      dif.disp_ready = ($urandom_range(0, 3) != 0);
      cpu_clken      = ($urandom_range(0, 4) != 0);
      pix_en         = ($urandom_range(0, 2) != 0);
      if (host_valid && host_ready) exp_q.push_back(exp_host(host_data));
      step();
    end
    host_valid     = 1'b0;
    dif.disp_ready = 1'b1;
    cpu_clken      = 1'b1;
    pix_en         = 1'b1;
    for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) step();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rand_char: got %h want %h", o, e); end
    end
  endtask

  task automatic test_spacing();
    n_checks++;
    if (gap_err != 0) begin n_fail++; $display("FAIL spacing: %0d writes without an idle cycle, want 0", gap_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    clr_ticks    = 0;
    wen_in_clear = 0;
    gap_err      = 0;
    prev_acc     = 1'b0;
    test_reset();
    test_single_cpu();
    test_ready_stall();
    test_round_robin();
    test_fifo_full();
    test_clear();
    test_host_xform();
    test_random_stream();
    test_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_tx_scheduler.md
Name: display_tx_scheduler

Overview:
- Sequences all traffic into the display's TX port and arbitrates between two character sources: the CPU (PIA port B write) and a host injection stream (paste/typing from the MiST IO controller), the latter buffered in a FIFO.
- Holds each character on the display port with a stable write strobe until the display accepts it.
- Owns screen clear: drives the display's clr_screen for exactly one full frame.

Parameters:
- FIFO_DEPTH, 16, host FIFO entries (power of 2, ≥2).
- CLEAR_TICKS, 119210, pixel_clken ticks clr_screen is held (455*262 = one frame).

Ports:
- sys_clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixel_clken  in  1  pixel clock enable (same as display).
- cpu_clken  in  1  cpu clock enable (same as display).
- cpu_wr  in  1  one-cycle CPU write strobe to the TX register.
- cpu_din  in  8  CPU character.
- cpu_busy  out  1  CPU holding slot occupied (feeds PB7 status).
- host_valid  in  1  host character valid.
- host_data  in  8  host character.
- host_ready  out  1  FIFO not full; a push occurs when host_valid & host_ready.
- clr_req  in  1  one-cycle clear-screen request.
- clr_busy  out  1  clear sequence in progress.
- disp_address  out  1  display address; constant 0 (TX register).
- disp_w_en  out  1  display write enable.
- disp_din  out  8  display data.
- disp_ready  in  1  display ready.
- disp_clr_screen  out  1  display clear-screen drive.
- cpu_drop  out  1  one-cycle pulse when a CPU write is discarded.

Behaviour:
- All state changes on posedge sys_clock. Reset is synchronous. Reset values:
  - outputs: cpu_busy=0, host_ready=1, clr_busy=0, disp_w_en=0, disp_din=0, disp_clr_screen=0, cpu_drop=0.
  - internal: FIFO empty, clr_pending=0, last_grant=HOST (so the CPU wins the first tie).
  - Reset mid-operation abandons any held character and any clear in progress.
- Accept condition: accept = disp_w_en & disp_ready & pixel_clken & cpu_clken.
- CPU slot (1 entry):
  - cpu_wr with slot empty loads cpu_din and sets cpu_busy next cycle.
  - cpu_wr with slot full is discarded and pulses cpu_drop for 1 cycle.
  - cpu_busy clears in the cycle after accept of a CPU grant.
- Host FIFO:
  - Push on host_valid & host_ready. Pop on grant.
  - host_ready=0 when FIFO_DEPTH entries are held.
  - Simultaneous push and pop when full is not allowed (host_ready already 0).
- clr_req sets clr_pending. A clr_req while clr_pending or CLEAR is active is absorbed (no restart).
- FSM states: IDLE, ISSUE, CLEAR.
  - IDLE: if clr_pending, go to CLEAR (clear beats characters). Otherwise, if either source is pending, grant and go to ISSUE.
    - Both pending: grant the source != last_grant (round robin). One pending: grant it.
    - On grant: disp_din <= char, disp_w_en <= 1, last_grant updated.
  - ISSUE: disp_w_en and disp_din held stable until accept. On accept: disp_w_en <= 0, go to IDLE. A clr_pending arriving here waits for the accept.
    - Minimum spacing is 1 idle cycle between characters, so the display sees each w_en as a distinct write.
  - CLEAR: clr_busy=1, disp_clr_screen=1, disp_w_en=0. Counter (17 bits) counts pixel_clken ticks from 0. When the count reaches CLEAR_TICKS-1 on a tick: clear clr_pending, counter <= 0, go to IDLE.
    - Sources keep filling (CPU slot, FIFO) during CLEAR; nothing is drained.
- disp_address tied 0. disp_din retains its last value when disp_w_en=0.
- Latency: a cpu_wr into an empty system drives disp_w_en=1 at cycle +2 (load, grant).

Optional Feature:
- Macro HOST_CRLF_EN.
- Defined: host characters are transformed at grant time. 0x0A becomes 0x8D (LF→CR, because the display ignores LF). All other host characters get bit7 forced to 1.
- Undefined: host characters pass unchanged.
- CPU characters are never transformed.

Decomposition:
- Package display_tx_pkg:
  - state enum {IDLE, ISSUE, CLEAR};
  - source enum {SRC_CPU, SRC_HOST};
  - CHR_CR=8'h8D, CHR_LF=8'h0A;
  - CLEAR_TICKS_DEFAULT=119210.
- Sub-module host_char_fifo: synchronous FIFO with valid/ready push and a pop strobe, parameterised by FIFO_DEPTH.

Test Plan:
- Single CPU char: cpu_wr with cpu_din=0xC1, disp_ready=1, both enables always 1 → disp_w_en=1 with disp_din=0xC1 at cycle +2. It drops the cycle after. cpu_busy goes 1 then 0.
- Ready stall: disp_ready=0 for 100 cycles after a grant of 0xB0 → disp_w_en and disp_din=0xB0 stay stable for all 100 cycles. Accept occurs on the first cycle with disp_ready=1.
- Round robin: FIFO holds 0x31,0x32 and cpu_wr 0xC1, 0xC2 are issued after each accept → display order is 0xC1,0x31,0xC2,0x32.
- FIFO full: push 16 host chars with disp_ready=0 → host_ready=0 after the 16th. A 17th host_valid is not accepted. A cpu_wr while cpu_busy=1 pulses cpu_drop.
- Clear: clr_req during ISSUE → the clear starts only after the accept. disp_clr_screen is high for exactly 119210 pixel_clken ticks (pixel_clken at 1/2 rate) with no disp_w_en during that time. A pending CPU char is issued afterwards.
- HOST_CRLF_EN: host 0x0A → disp_din=0x8D; host 0x41 → 0xC1. With the macro undefined: 0x0A and 0x41 pass unchanged.
